// File: rtl/game_sequencer.sv
// Frame-rate game controller: IDLE/PLAY/HIT/OVER sequencing, difficulty ramp, lives and score.
// Decisions are taken only on refresh_tick and appear the cycle after it; there is no backpressure.
module game_sequencer #(
    parameter int LIVES_INIT    = 3,
    parameter int START_SQUARES = 5,
    parameter int MAX_SQUARES   = 16,
    parameter int LEVEL_FRAMES  = 600,
    parameter int HIT_FRAMES    = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        refresh_tick,
    input  logic        btn_start,
    input  logic        collision,
    output logic        run,
    output logic [5:0]  num_squares,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [3:0]  level,
    output logic        flash,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HIT  = 2'b10,
        S_OVER = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        run_d, flash_d;
    logic [5:0]  num_squares_d;
    logic [1:0]  lives_d;
    logic [15:0] score_d;
    logic [3:0]  level_d;
    logic [15:0] frame_cnt, frame_cnt_d;
    logic [7:0]  hit_cnt, hit_cnt_d;
    logic        btn_prev;
    logic        press;

    assign press = btn_start & ~btn_prev;
    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            run         <= 1'b0;
            num_squares <= 6'(START_SQUARES);
            lives       <= 2'(LIVES_INIT);
            score       <= '0;
            level       <= '0;
            flash       <= 1'b0;
            frame_cnt   <= '0;
            hit_cnt     <= '0;
            btn_prev    <= 1'b0;
        end else if (refresh_tick) begin
            state_q     <= state_d;
            run         <= run_d;
            num_squares <= num_squares_d;
            lives       <= lives_d;
            score       <= score_d;
            level       <= level_d;
            flash       <= flash_d;
            frame_cnt   <= frame_cnt_d;
            hit_cnt     <= hit_cnt_d;
            btn_prev    <= btn_start;
        end
    end

    always_comb begin
        state_d       = state_q;
        run_d         = 1'b0;
        flash_d       = 1'b0;
        num_squares_d = num_squares;
        lives_d       = lives;
        score_d       = score;
        level_d       = level;
        frame_cnt_d   = frame_cnt;
        hit_cnt_d     = hit_cnt;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d       = S_PLAY;
                    run_d         = 1'b1;
                    lives_d       = 2'(LIVES_INIT);
                    score_d       = '0;
                    level_d       = '0;
                    num_squares_d = 6'(START_SQUARES);
                    frame_cnt_d   = '0;
                end
            end
            S_PLAY: begin
                run_d = 1'b1;
                // A hit wins over a level step landing on the same frame.
                if (collision) begin
                    run_d   = 1'b0;
                    lives_d = lives - 2'd1;
                    if (lives == 2'd1) begin
                        state_d = S_OVER;
                    end else begin
                        state_d   = S_HIT;
                        hit_cnt_d = '0;
                    end
                end else begin
                    if (score != 16'hFFFF)
                        score_d = score + 16'd1;
                    if (frame_cnt == 16'(LEVEL_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        if (level != 4'd15)
                            level_d = level + 4'd1;
                        if (num_squares < 6'(MAX_SQUARES))
                            num_squares_d = num_squares + 6'd1;
                    end else begin
                        frame_cnt_d = frame_cnt + 16'd1;
                    end
                end
            end
            S_HIT: begin
                flash_d   = hit_cnt[3];
                hit_cnt_d = hit_cnt + 8'd1;
                if (hit_cnt == 8'(HIT_FRAMES - 1)) begin
                    state_d = S_PLAY;
                    run_d   = 1'b1;
                    flash_d = 1'b0;
                end
            end
            S_OVER: begin
                if (press)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a behavioural model queues expected outputs per tick, compared one cycle later.
module tb_game_sequencer;

    localparam int LF   = 4;
    localparam int HF   = 16;
    localparam int LINI = 3;
    localparam int SSQ  = 5;
    localparam int MSQ  = 7;

    logic        clk = 1'b0;
    logic        reset, refresh_tick, btn_start, collision;
    logic        run, flash;
    logic [5:0]  num_squares;
    logic [1:0]  lives, state;
    logic [15:0] score;
    logic [3:0]  level;

    always #5 clk = ~clk;

    game_sequencer #(
        .LIVES_INIT(LINI), .START_SQUARES(SSQ), .MAX_SQUARES(MSQ),
        .LEVEL_FRAMES(LF), .HIT_FRAMES(HF)
    ) dut (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn_start(btn_start),
        .collision(collision), .run(run), .num_squares(num_squares), .lives(lives),
        .score(score), .level(level), .flash(flash), .state(state)
    );

    typedef struct packed {
        logic        run;
        logic [5:0]  ns;
        logic [1:0]  lives;
        logic [15:0] score;
        logic [3:0]  level;
        logic        flash;
        logic [1:0]  state;
    } exp_t;

    exp_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [1:0]  m_state;
    logic        m_run, m_flash, m_btn_prev;
    logic [5:0]  m_ns;
    logic [1:0]  m_lives;
    logic [15:0] m_score;
    logic [3:0]  m_level;
    int          m_frame, m_hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.run = m_run; e.ns = m_ns; e.lives = m_lives; e.score = m_score;
        e.level = m_level; e.flash = m_flash; e.state = m_state;
        return e;
    endfunction

    task automatic model_reset();
        m_state = 2'd0; m_run = 1'b0; m_flash = 1'b0; m_btn_prev = 1'b0;
        m_ns = 6'(SSQ); m_lives = 2'(LINI); m_score = 16'd0; m_level = 4'd0;
        m_frame = 0; m_hit = 0;
    endtask

    task automatic model_tick(input logic btn, input logic col);
        logic pr;
        pr = btn && !m_btn_prev;
        m_btn_prev = btn;
        case (m_state)
            2'd0: if (pr) begin
                m_state = 2'd1; m_run = 1'b1; m_lives = 2'(LINI); m_score = 16'd0;
                m_level = 4'd0; m_ns = 6'(SSQ); m_frame = 0;
            end
            2'd1: if (col) begin
                m_run = 1'b0;
                if (m_lives == 2'd1) begin
                    m_state = 2'd3; m_lives = 2'd0;
                end else begin
                    m_state = 2'd2; m_lives = m_lives - 2'd1; m_hit = 0;
                end
            end else begin
                if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
                if (m_frame == LF - 1) begin
                    m_frame = 0;
                    if (m_level < 4'd15) m_level = m_level + 4'd1;
                    if (m_ns < 6'(MSQ)) m_ns = m_ns + 6'd1;
                end else begin
                    m_frame = m_frame + 1;
                end
            end
            2'd2: begin
                // blink with period 16 frames: lit while the count sits in 8..15
                m_flash = ((m_hit % 16) >= 8);
                if (m_hit == HF - 1) begin
                    m_state = 2'd1; m_run = 1'b1; m_flash = 1'b0;
                end else begin
                    m_hit = m_hit + 1;
                end
            end
            default: if (pr) m_state = 2'd0;
        endcase
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, "_state"}, 32'(state), 32'(e.state));
        chk({tag, "_run"},   32'(run),   32'(e.run));
        chk({tag, "_ns"},    32'(num_squares), 32'(e.ns));
        chk({tag, "_lives"}, 32'(lives), 32'(e.lives));
        chk({tag, "_score"}, 32'(score), 32'(e.score));
        chk({tag, "_level"}, 32'(level), 32'(e.level));
        chk({tag, "_flash"}, 32'(flash), 32'(e.flash));
    endtask

    task automatic do_tick(input logic btn, input logic col);
        exp_t e;
        @(negedge clk);
        btn_start = btn; collision = col; refresh_tick = 1'b1;
        model_tick(btn, col);
        sb_q.push_back(cur_exp());
        @(negedge clk);
        refresh_tick = 1'b0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_all("tick", e);
        end
    endtask

    task automatic do_idle(input int n, input logic btn, input logic col);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_start = btn; collision = col;
        end
        @(negedge clk);
        check_all("hold", cur_exp());
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; btn_start = 1'b0; collision = 1'b0; refresh_tick = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; refresh_tick = 1'b0; btn_start = 1'b0; collision = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_ns",    32'(num_squares), 32'd5);
        reset = 1'b0;

        // 1: idle ticks without button
        for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0);
        chk("t1_state", 32'(state), 32'd0);
        chk("t1_run",   32'(run),   32'd0);
        chk("t1_score", 32'(score), 32'd0);

        // 2: held button starts once
        for (int i = 1; i <= 10; i++) begin
            do_tick(1'b1, 1'b0);
            if (i == 1) chk("t2_start", 32'(state), 32'd1);
        end
        chk("t2_score", 32'(score), 32'd9);
        chk("t2_run",   32'(run),   32'd1);
        do_idle(3, 1'b0, 1'b1);

        // 3: fresh game, 12 clean frames
        apply_reset();
        do_tick(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) do_tick(1'b0, 1'b0);
        chk("t3_level", 32'(level), 32'd3);
        chk("t3_ns",    32'(num_squares), 32'd7);
        chk("t3_score", 32'(score), 32'd12);

        // 4: first hit and the freeze window
        do_tick(1'b0, 1'b1);
        chk("t4_lives", 32'(lives), 32'd2);
        chk("t4_state", 32'(state), 32'd2);
        chk("t4_score", 32'(score), 32'd12);
        for (int k = 1; k <= 16; k++) begin
            do_tick(1'b1, k == 3);
            if (k == 8)  chk("t4_flash8",  32'(flash), 32'd0);
            if (k == 9)  chk("t4_flash9",  32'(flash), 32'd1);
            if (k == 15) chk("t4_flash15", 32'(flash), 32'd1);
        end
        chk("t4_resume", 32'(state), 32'd1);
        chk("t4_run",    32'(run),   32'd1);
        chk("t4_lives2", 32'(lives), 32'd2);

        // 5: lose remaining lives, restart
        do_tick(1'b0, 1'b1);
        for (int k = 0; k < 16; k++) do_tick(1'b0, 1'b0);
        do_tick(1'b0, 1'b0);
        do_tick(1'b0, 1'b1);
        chk("t5_over",  32'(state), 32'd3);
        chk("t5_lives", 32'(lives), 32'd0);
        do_tick(1'b0, 1'b0);
        chk("t5_frozen", 32'(score), 32'd13);
        do_tick(1'b1, 1'b0);
        chk("t5_idle",   32'(state), 32'd0);
        chk("t5_keeplv", 32'(level), 32'd3);
        do_tick(1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        chk("t5_play",  32'(state), 32'd1);
        chk("t5_lives3", 32'(lives), 32'd3);
        chk("t5_score0", 32'(score), 32'd0);
        chk("t5_level0", 32'(level), 32'd0);
        chk("t5_ns5",    32'(num_squares), 32'd5);

        // 6: async reset during HIT, then hit on a level-step frame
        do_tick(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) do_tick(1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t6_arst_state", 32'(state), 32'd0);
        chk("t6_arst_lives", 32'(lives), 32'd3);
        chk("t6_arst_run",   32'(run),   32'd0);
        chk("t6_arst_flash", 32'(flash), 32'd0);
        chk("t6_arst_score", 32'(score), 32'd0);
        chk("t6_arst_ns",    32'(num_squares), 32'd5);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        do_tick(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) do_tick(1'b0, 1'b0);
        do_tick(1'b0, 1'b1);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_lives", 32'(lives), 32'd2);
        chk("t6_ns",    32'(num_squares), 32'd5);
        do_idle(2, 1'b1, 1'b1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
